// File: rtl/seq_enumerator_pkg.sv
// Shared types and helpers for the sequence enumerator.
// Holds the FSM state encoding and digit-slicing arithmetic.
package seq_enumerator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESULT,
        DONE
    } state_t;

    // Low bit of position p in a packed digit vector of stride w
    function automatic int act_lo(input int p, input int w);
        return p * w;
    endfunction

    // Number of sequences in a full pass: n^d
    function automatic int total_seqs(input int n, input int d);
        int t;
        t = 1;
        for (int i = 0; i < d; i++) begin
            t = t * n;
        end
        return t;
    endfunction

endpackage

// File: rtl/seq_odometer.sv
// DEPTH-digit mixed-radix counter; position 0 is the most significant digit.
// Supports clear, increment with carry, an all-max flag and a digit read port.
module seq_odometer
    import seq_enumerator_pkg::*;
#(
    parameter int NUM_ACTIONS = 3,
    parameter int DEPTH       = 2,
    parameter int ACTION_W    = 2,
    parameter int POS_W       = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      incr,
    input  logic [POS_W-1:0]          sel,
    output logic [ACTION_W-1:0]       digit,
    output logic [DEPTH*ACTION_W-1:0] digits,
    output logic                      all_max
);

    localparam logic [ACTION_W-1:0] MAXD = ACTION_W'(NUM_ACTIONS - 1);

    logic [DEPTH*ACTION_W-1:0] digs;
    logic [DEPTH*ACTION_W-1:0] nxt;
    logic [ACTION_W-1:0]       cur;
    logic                      carry;

    // Ripple increment from the least-significant digit upward
    always_comb begin
        nxt   = digs;
        cur   = '0;
        carry = 1'b1;
        for (int p = DEPTH - 1; p >= 0; p--) begin
            cur = digs[act_lo(p, ACTION_W) +: ACTION_W];
            if (carry) begin
                if (cur == MAXD) begin
                    nxt[act_lo(p, ACTION_W) +: ACTION_W] = '0;
                end else begin
                    nxt[act_lo(p, ACTION_W) +: ACTION_W] = cur + ACTION_W'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    // Digit select and terminal-count detection
    always_comb begin
        digit   = '0;
        all_max = 1'b1;
        for (int p = 0; p < DEPTH; p++) begin
            if (sel == POS_W'(p)) begin
                digit = digs[act_lo(p, ACTION_W) +: ACTION_W];
            end
            if (digs[act_lo(p, ACTION_W) +: ACTION_W] != MAXD) begin
                all_max = 1'b0;
            end
        end
    end

    // Digit register; clear takes priority over increment
    always_ff @(posedge clock) begin
        if (reset) begin
            digs <= '0;
        end else if (clear) begin
            digs <= '0;
        end else if (incr) begin
            digs <= nxt;
        end
    end

    assign digits = digs;

endmodule

// File: rtl/seq_enumerator.sv
// Exhaustive action-sequence enumerator feeding a property-check harness.
// Streams each sequence over valid/ready, then waits for a pass/fail verdict.
module seq_enumerator
    import seq_enumerator_pkg::*;
#(
    parameter int NUM_ACTIONS = 3,
    parameter int DEPTH       = 2,
    parameter int ACTION_W    = 2,
    parameter int COUNT_W     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      act_valid,
    input  logic                      act_ready,
    output logic [ACTION_W-1:0]       act_id,
    output logic                      act_first,
    output logic                      act_last,
    input  logic                      result_valid,
    input  logic                      result_pass,
    output logic                      busy,
    output logic                      done,
    output logic                      failed,
    output logic [COUNT_W-1:0]        seq_count,
    output logic [COUNT_W-1:0]        fail_seq_idx,
    output logic [DEPTH*ACTION_W-1:0] fail_actions
);

    localparam int POS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(DEPTH - 1);

    state_t                    state;
    state_t                    state_next;
    logic [POS_W-1:0]          pos;
    logic                      od_clear;
    logic                      od_incr;
    logic                      accept;
    logic                      verdict;
    logic                      is_last;
    logic                      all_max;
    logic [DEPTH*ACTION_W-1:0] digits;

    seq_odometer #(
        .NUM_ACTIONS(NUM_ACTIONS),
        .DEPTH      (DEPTH),
        .ACTION_W   (ACTION_W),
        .POS_W      (POS_W)
    ) u_odometer (
        .clock  (clock),
        .reset  (reset),
        .clear  (od_clear),
        .incr   (od_incr),
        .sel    (pos),
        .digit  (act_id),
        .digits (digits),
        .all_max(all_max)
    );

    assign is_last = (pos == LAST_POS);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        od_clear   = 1'b0;
        od_incr    = 1'b0;
        accept     = 1'b0;
        verdict    = 1'b0;
        act_valid  = 1'b0;
        act_first  = 1'b0;
        act_last   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    od_clear   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                act_valid = 1'b1;
                act_first = (pos == '0);
                act_last  = is_last;
                if (act_ready) begin
                    accept = 1'b1;
                    if (is_last) begin
                        state_next = WAIT_RESULT;
                    end
                end
            end
            WAIT_RESULT: begin
                busy = 1'b1;
                if (result_valid) begin
                    verdict = 1'b1;
                    if (!result_pass || all_max) begin
                        state_next = DONE;
                    end else begin
                        od_incr    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Position counter and verdict bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            pos          <= '0;
            seq_count    <= '0;
            failed       <= 1'b0;
            fail_seq_idx <= '0;
            fail_actions <= '0;
        end else if (od_clear) begin
            pos          <= '0;
            seq_count    <= '0;
            failed       <= 1'b0;
            fail_seq_idx <= '0;
            fail_actions <= '0;
        end else begin
            if (accept) begin
                pos <= is_last ? '0 : pos + POS_W'(1);
            end
            if (verdict) begin
                seq_count <= seq_count + COUNT_W'(1);
                if (!result_pass) begin
                    failed       <= 1'b1;
                    fail_seq_idx <= seq_count;
                    fail_actions <= digits;
                end
            end
        end
    end

endmodule
